// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter draining a first-word-fall-through byte FIFO
//
// Purpose:
//   Pops characters from a FWFT FIFO and serialises each one as 8N1 or 8N2
//   (start bit, DATA_WIDTH data bits LSB first, one or two stop bits) on tx.
//   Bit length is a run-time clocks-per-bit divisor. When the FIFO still
//   holds data at the end of a frame, the next character is taken in the
//   last stop-bit clock so frames follow each other with no idle gap.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   fifo_dout  head-of-FIFO data, valid whenever fifo_empty is low
//   fifo_empty FIFO has no data
//   fifo_pop   one-cycle pop strobe, combinational from the capture condition
//   div        clocks per bit, 0 behaves as 1, sampled at each capture
//   two_stop   1 = two stop bits, sampled at each capture
//   tx         serial line, idle high, registered
//   busy       high from the cycle after a capture through the last stop clock

module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  two_stop,
  output logic                  tx,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   shift, shift_n;
  logic [DIV_WIDTH-1:0]    div_l, div_l_n;
  logic                    two_l, two_l_n;
  logic [DIV_WIDTH-1:0]    bit_cnt, bit_cnt_n;
  logic [IDX_W-1:0]        bit_idx, bit_idx_n;
  logic                    stop_idx, stop_idx_n;
  logic                    tx_r, tx_n;

  logic                    capture;
  logic                    bit_end;
  logic [DIV_WIDTH-1:0]    div_eff;
  logic [DIV_WIDTH-1:0]    reload;

  // A zero divisor would never let the countdown terminate cleanly, so it
  // is promoted to one clock per bit.
  assign div_eff = (div == '0) ? DIV_WIDTH'(1) : div;
  assign reload  = div_l - DIV_WIDTH'(1);
  assign bit_end = (bit_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      div_l    <= '0;
      two_l    <= 1'b0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_r     <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      div_l    <= div_l_n;
      two_l    <= two_l_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      tx_r     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    div_l_n    = div_l;
    two_l_n    = two_l;
    bit_cnt_n  = bit_cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    capture    = 1'b0;
    tx_n       = 1'b1;

    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        if (!fifo_empty) begin
          capture = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = reload;
          bit_idx_n = '0;
        end else begin
          bit_cnt_n = bit_cnt - DIV_WIDTH'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_n   = shift >> 1;
          bit_cnt_n = reload;
          if (bit_idx == LAST_IDX) begin
            state_n    = STOP;
            stop_idx_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          bit_cnt_n = bit_cnt - DIV_WIDTH'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          if (two_l && !stop_idx) begin
            stop_idx_n = 1'b1;
            bit_cnt_n  = reload;
          end else if (!fifo_empty) begin
            // Last stop clock with more data waiting: chain straight into
            // the next start bit.
            capture = 1'b1;
          end else begin
            state_n   = IDLE;
            bit_cnt_n = '0;
          end
        end else begin
          bit_cnt_n = bit_cnt - DIV_WIDTH'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Capture overrides whatever the state logic chose: the frame settings
    // are frozen here and hold until the next capture.
    if (capture) begin
      state_n    = START;
      shift_n    = fifo_dout;
      div_l_n    = div_eff;
      two_l_n    = two_stop;
      bit_cnt_n  = div_eff - DIV_WIDTH'(1);
      bit_idx_n  = '0;
      stop_idx_n = 1'b0;
    end

    // tx is registered from the next state so it changes exactly on the
    // bit boundaries, one clock after the capture for the start bit.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign fifo_pop = capture && !reset;
  assign tx       = tx_r;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - self-checking bench for uart_tx_fifo_drain
module tb_uart_tx_fifo_drain;

  logic        clk;
  logic        reset;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [15:0] div;
  logic        two_stop;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .div        (div),
    .two_stop   (two_stop),
    .tx         (tx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void refresh_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() == 0) ? 8'h00 : fq[0];
  endfunction

  // FWFT FIFO model: pop takes effect just after the edge that consumed it.
  always @(posedge clk) begin
    if (fifo_pop) begin
      #1;
      if (fq.size() != 0) void'(fq.pop_front());
      refresh_fifo();
    end
  end

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    refresh_fifo();
  endtask

  task automatic wait_pop(input string name);
    int n;
    n = 0;
    #1;
    while (!fifo_pop && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL %s_pop_timeout: fifo_pop=%b after %0d cycles, expected 1", name, fifo_pop, n);
    end
  endtask

  // Called in the pop cycle (cycle 0); checks cycles 1..frame length.
  task automatic run_frame(input string name, input int d, input bit ts, input bit nxt,
                           input int chg_at, input logic [15:0] chg_div);
    logic [7:0] exp_b;
    logic [7:0] dec;
    logic       e;
    int         len, b, ph;
    dec = 8'h00;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue size=%0d, expected nonzero", name, exp_q.size());
      return;
    end
    exp_b = exp_q.pop_front();
    len = d * (10 + (ts ? 1 : 0));
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      #1;
      b  = (k - 1) / d;
      ph = (k - 1) % d;
      if (b == 0)      e = 1'b0;
      else if (b <= 8) e = exp_b[b-1];
      else             e = 1'b1;
      checks++;
      if (tx !== e) begin
        errors++;
        $display("FAIL %s_tx_c%0d: tx=%b expected %b", name, k, tx, e);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy_c%0d: busy=%b expected 1", name, k, busy);
      end
      checks++;
      if (fifo_pop !== ((k == len) && nxt)) begin
        errors++;
        $display("FAIL %s_pop_c%0d: fifo_pop=%b expected %b", name, k, fifo_pop, (k == len) && nxt);
      end
      if (b >= 1 && b <= 8 && ph == 0) dec[b-1] = tx;
      if (k == chg_at) div = chg_div;
    end
    checks++;
    if (dec !== exp_b) begin
      errors++;
      $display("FAIL %s_byte: decoded=%02h expected %02h", name, dec, exp_b);
    end
    if (!nxt) begin
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        errors++;
        $display("FAIL %s_idle: busy=%b tx=%b expected busy=0 tx=1", name, busy, tx);
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b pop=%b expected 1 0 0", tx, busy, fifo_pop);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
        errors++;
        $display("FAIL idle_empty_c%0d: tx=%b busy=%b pop=%b expected 1 0 0", i, tx, busy, fifo_pop);
      end
    end
  endtask

  task automatic test_single();
    div = 16'd4;
    two_stop = 1'b0;
    push_byte(8'h55);
    wait_pop("single");
    run_frame("single", 4, 1'b0, 1'b0, 0, 16'd0);
  endtask

  task automatic test_back_to_back();
    div = 16'd4;
    two_stop = 1'b0;
    push_byte(8'hA3);
    push_byte(8'h0F);
    wait_pop("b2b");
    run_frame("b2b_first", 4, 1'b0, 1'b1, 0, 16'd0);
    run_frame("b2b_second", 4, 1'b0, 1'b0, 0, 16'd0);
  endtask

  task automatic test_div_zero_two_stop();
    div = 16'd0;
    two_stop = 1'b1;
    push_byte(8'hFF);
    wait_pop("div0");
    run_frame("div0", 1, 1'b1, 1'b0, 0, 16'd0);
    two_stop = 1'b0;
  endtask

  task automatic test_div_change();
    div = 16'd8;
    two_stop = 1'b0;
    push_byte(8'h00);
    push_byte(8'h5A);
    wait_pop("divchg");
    run_frame("divchg_first", 8, 1'b0, 1'b1, 30, 16'd2);
    run_frame("divchg_second", 2, 1'b0, 1'b0, 0, 16'd0);
  endtask

  task automatic test_reset_mid_frame();
    div = 16'd4;
    two_stop = 1'b0;
    push_byte(8'h3C);
    push_byte(8'hC5);
    wait_pop("rstmid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: tx=%b busy=%b pop=%b expected 1 0 0", tx, busy, fifo_pop);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (fifo_pop !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_first_pop: fifo_pop=%b expected 1", fifo_pop);
    end
    run_frame("rstmid_after", 4, 1'b0, 1'b0, 0, 16'd0);
  endtask

  initial begin
    reset    = 1'b1;
    div      = 16'd4;
    two_stop = 1'b0;
    refresh_fifo();
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_div_zero_two_stop();
    test_div_change();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
UART transmitter that is the read-side consumer of the SoC's byte FIFO. It pops bytes from a first-word-fall-through FIFO and serialises each byte as 8N1 or 8N2 on the tx pin. It sits between the CPU-facing TX FIFO and the pad. Baud timing comes from a run-time clocks-per-bit divisor.

Parameters:
DATA_WIDTH, 8, bits per character, shifted out LSB first.
DIV_WIDTH, 16, width of the clocks-per-bit divisor input.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
fifo_dout  input  DATA_WIDTH  head-of-FIFO data; combinational read, valid whenever fifo_empty=0.
fifo_empty  input  1  FIFO has no data.
fifo_pop  output  1  one-cycle pop strobe to the FIFO.
div  input  DIV_WIDTH  clocks per bit; value 0 is treated as 1.
two_stop  input  1  1 = two stop bits, 0 = one stop bit.
tx  output  1  serial line, idle high.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async): state=IDLE, tx=1, fifo_pop=0, busy=0, counters and shift register cleared. A reset mid-frame aborts the frame at once and tx returns high. The popped byte is lost and is not re-popped.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0.
  - When fifo_empty=0, the block asserts fifo_pop for that cycle only.
  - In the same cycle it captures fifo_dout into the shift register, and latches div (0->1) and two_stop for the whole frame.
  - Next state is START.
- fifo_pop is registered-free combinational: fifo_pop = capture condition. It is never asserted while fifo_empty=1 and is never high for two consecutive cycles for the same byte.
- Bit timing: a bit counter loads div_l-1 on entering each bit and counts down to 0. Each bit lasts exactly div_l clocks.
- START: tx=0 for div_l clocks, then DATA.
- DATA: tx=shift[0]. At the end of each bit the register shifts right. After DATA_WIDTH bits, go to STOP.
- STOP: tx=1 for div_l clocks (2*div_l if two_stop latched).
- Last clock of STOP:
  - If fifo_empty=0: pop and capture the next byte in this cycle (same rules as IDLE) and go directly to START. Back-to-back frames have no gap.
  - Otherwise go to IDLE.
- Frame length: div_l*(DATA_WIDTH+2) clocks, or div_l*(DATA_WIDTH+3) with two stop bits.
- busy=1 from the cycle after a capture through the last STOP cycle. busy is continuously high across back-to-back frames.
- Changes to div and two_stop mid-frame have no effect until the next capture.
- tx first goes low one clock after the pop cycle (registered tx output).

Test Plan:
- Reset, fifo_empty=1 held 100 cycles -> tx=1, busy=0, fifo_pop never asserted.
- div=4, two_stop=0, FIFO holds 0x55 -> one fifo_pop pulse.
  - tx low cycles 1-4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, stop high cycles 37-40.
  - busy high for exactly 40 cycles, then IDLE.
- FIFO holds 0xA3, 0x0F, div=4 -> pops at cycle 0 and cycle 40 (last STOP cycle).
  - Second start bit begins at cycle 41; 80 contiguous busy cycles.
  - Decoded bytes are 0xA3 then 0x0F.
- div=0, two_stop=1, byte 0xFF -> 1-clock bits: start low 1 cycle, 8 high, 2 stop high. busy lasts 11 cycles.
- div=8 and byte 0x00 in flight; at cycle 30 change div to 2 -> current frame keeps 8-clock bits. The next frame uses 2-clock bits.
- Assert reset at cycle 20 of a div=4 frame -> tx=1 and busy=0 immediately.
  - After release with FIFO non-empty, the next byte is popped on the first clock and a full frame follows.
